// File: rtl/touch_panel_spi_slave.sv
// touch_panel_spi_slave
//   SPI slave (CPOL=0, CPHA=0, 8 bits, MSB first) with a small CPU register
//   file for a touch-panel controller. SPI pins are asynchronous to clk and
//   are oversampled through 2-flop synchronizers. SCLK must be <= clk/8.
//
// Ports
//   clk, reset      system clock, synchronous active-high reset
//   SCLK/SS_n/MOSI  SPI inputs from the external master (asynchronous)
//   MISO, MISO_oe   SPI data out and its output enable (high while selected)
//   spi_select      CPU chip select
//   mem_addr        register address: 0 rx, 1 tx, 2 status, 3 control
//   read_n/write_n  CPU strobes, active low, sampled every clk
//   data_from_cpu   write data
//   data_to_cpu     registered read data (valid one cycle after mem_addr)
//   irq             registered interrupt
module touch_panel_spi_slave (
    input  logic        clk,
    input  logic        reset,
    input  logic        SCLK,
    input  logic        SS_n,
    input  logic        MOSI,
    output logic        MISO,
    output logic        MISO_oe,
    input  logic        spi_select,
    input  logic [2:0]  mem_addr,
    input  logic        read_n,
    input  logic        write_n,
    input  logic [15:0] data_from_cpu,
    output logic [15:0] data_to_cpu,
    output logic        irq
);

    typedef enum logic [1:0] {IDLE, LOAD, SHIFT} state_t;

    // [0] first sync stage, [1] synchronized value, [2] edge-detect delay
    logic [2:0] sclk_q, ss_q;
    logic [1:0] mosi_q;

    state_t      state_q;
    logic [7:0]  shift_q, rx_shift_q, rx_hold_q, tx_hold_q;
    logic [3:0]  bit_cnt_q;
    logic        rrdy_q, trdy_q, roe_q, tur_q;
    logic [2:0]  ctrl_q;             // {iE, iRRDY, iTRDY}
    logic [15:0] data_to_cpu_q;
    logic        irq_q;

    logic sclk_rise, sclk_fall, ss_fall, ss_rise, mosi_s, sel;
    logic wr, rd, wr_tx, wr_stat, wr_ctrl, rd_rx, load_now, err;
    logic [15:0] status, rd_mux;
    logic unused_hi;

    assign sclk_rise = sclk_q[1] & ~sclk_q[2];
    assign sclk_fall = ~sclk_q[1] & sclk_q[2];
    assign ss_fall   = ~ss_q[1] & ss_q[2];
    assign ss_rise   = ss_q[1] & ~ss_q[2];
    assign mosi_s    = mosi_q[1];
    assign sel       = ~ss_q[1];

    assign wr      = spi_select & ~write_n;
    assign rd      = spi_select & ~read_n;
    assign wr_tx   = wr & (mem_addr == 3'd1);
    assign wr_stat = wr & (mem_addr == 3'd2);
    assign wr_ctrl = wr & (mem_addr == 3'd3);
    assign rd_rx   = rd & (mem_addr == 3'd0);
    assign unused_hi = ^data_from_cpu[15:8];

    // Shift register (re)load: entering a frame, or at the 8th SCLK fall so
    // the next byte's MSB is on MISO before the next rising edge.
    assign load_now = ~ss_rise & ((state_q == LOAD) ||
                      (state_q == SHIFT && sclk_fall && bit_cnt_q == 4'd8));

    assign err    = roe_q | tur_q;
    assign status = {8'b0, err, rrdy_q, trdy_q, sel, tur_q, roe_q, 2'b0};

    always_comb begin
        rd_mux = '0;
        case (mem_addr)
            3'd0:    rd_mux = {8'b0, rx_hold_q};
            3'd2:    rd_mux = status;
            3'd3:    rd_mux = {8'b0, ctrl_q, 5'b0};
            default: rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sclk_q        <= 3'b000;
            ss_q          <= 3'b111;
            mosi_q        <= 2'b00;
            state_q       <= IDLE;
            shift_q       <= '0;
            rx_shift_q    <= '0;
            rx_hold_q     <= '0;
            tx_hold_q     <= '0;
            bit_cnt_q     <= '0;
            rrdy_q        <= 1'b0;
            trdy_q        <= 1'b1;
            roe_q         <= 1'b0;
            tur_q         <= 1'b0;
            ctrl_q        <= '0;
            data_to_cpu_q <= '0;
            irq_q         <= 1'b0;
        end else begin
            sclk_q <= {sclk_q[1:0], SCLK};
            ss_q   <= {ss_q[1:0], SS_n};
            mosi_q <= {mosi_q[0], MOSI};

            data_to_cpu_q <= rd_mux;
            irq_q <= (err & ctrl_q[2]) | (rrdy_q & ctrl_q[1]) | (trdy_q & ctrl_q[0]);

            if (wr_ctrl) ctrl_q <= data_from_cpu[7:5];
            // Clears come first so a same-cycle set event below wins.
            if (wr_stat) begin
                roe_q <= 1'b0;
                tur_q <= 1'b0;
            end
            if (rd_rx) rrdy_q <= 1'b0;

            if (ss_rise) begin
                state_q <= IDLE;
            end else begin
                case (state_q)
                    IDLE:  if (ss_fall) state_q <= LOAD;
                    LOAD: begin
                        bit_cnt_q <= '0;
                        state_q   <= SHIFT;
                    end
                    SHIFT: begin
                        if (sclk_rise) begin
                            rx_shift_q <= {rx_shift_q[6:0], mosi_s};
                            bit_cnt_q  <= bit_cnt_q + 4'd1;
                            if (bit_cnt_q == 4'd7) begin
                                rx_hold_q <= {rx_shift_q[6:0], mosi_s};
                                rrdy_q    <= 1'b1;
                                // A read in this same cycle consumes the old byte.
                                if (rrdy_q && !rd_rx) roe_q <= 1'b1;
                            end
                        end else if (sclk_fall) begin
                            if (bit_cnt_q == 4'd8)
                                bit_cnt_q <= '0;
                            else if (bit_cnt_q != 4'd0)
                                shift_q <= {shift_q[6:0], 1'b0};
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end

            if (load_now) begin
                if (!trdy_q) begin
                    shift_q <= tx_hold_q;
                end else begin
                    shift_q <= 8'h00;
                    tur_q   <= 1'b1;
                end
                trdy_q <= 1'b1;
            end

            // Placed after the load so a write landing on an underrun reload
            // is kept for the following byte.
            if (wr_tx && trdy_q) begin
                tx_hold_q <= data_from_cpu[7:0];
                trdy_q    <= 1'b0;
            end
        end
    end

    assign MISO        = (state_q != IDLE) & shift_q[7];
    assign MISO_oe     = sel;
    assign data_to_cpu = data_to_cpu_q;
    assign irq         = irq_q;

endmodule

// File: tb/tb_touch_panel_spi_slave.sv
// Directed testbench for touch_panel_spi_slave: basic transfer, underrun and
// overrun, abort, read/complete collision, interrupt timing, mid-byte reset.
`timescale 1ns/1ps
module tb_touch_panel_spi_slave;

    logic        clk = 1'b0;
    logic        reset, SCLK, SS_n, MOSI, MISO, MISO_oe;
    logic        spi_select, read_n, write_n, irq;
    logic [2:0]  mem_addr;
    logic [15:0] data_from_cpu, data_to_cpu;

    int checks = 0;
    int errors = 0;
    logic [15:0] rv, coll_data;
    logic [7:0]  r1, r2;
    logic        found, prev_irq;

    localparam time HALF = 80ns;   // SCLK = clk/16

    always #5 clk = ~clk;

    touch_panel_spi_slave dut (
        .clk(clk), .reset(reset), .SCLK(SCLK), .SS_n(SS_n), .MOSI(MOSI),
        .MISO(MISO), .MISO_oe(MISO_oe), .spi_select(spi_select),
        .mem_addr(mem_addr), .read_n(read_n), .write_n(write_n),
        .data_from_cpu(data_from_cpu), .data_to_cpu(data_to_cpu), .irq(irq)
    );

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cpu_wr(input logic [2:0] a, input logic [15:0] d);
        @(negedge clk);
        mem_addr = a; data_from_cpu = d; spi_select = 1'b1; write_n = 1'b0;
        @(negedge clk);
        spi_select = 1'b0; write_n = 1'b1;
    endtask

    task automatic cpu_rd(input logic [2:0] a, output logic [15:0] d);
        @(negedge clk);
        mem_addr = a; spi_select = 1'b1; read_n = 1'b0;
        @(negedge clk);
        d = data_to_cpu;
        spi_select = 1'b0; read_n = 1'b1;
    endtask

    // Read without a strobe: data_to_cpu follows mem_addr regardless.
    task automatic peek(input logic [2:0] a, output logic [15:0] d);
        @(negedge clk);
        mem_addr = a;
        @(negedge clk);
        d = data_to_cpu;
    endtask

    // Master side of one byte; MISO captured at each SCLK rise. With collide
    // set, the 8th rise is clk-aligned so an rx read lands on the same clk
    // as the DUT's completion (2 sync flops + edge detect = 3rd posedge).
    task automatic spi_byte(input logic [7:0] tx, output logic [7:0] rx,
                            input int nbits, input bit collide);
        rx = '0;
        for (int i = 7; i > 7 - nbits; i--) begin
            MOSI = tx[i];
            #HALF;
            if (collide && i == 0) begin
                @(negedge clk); SCLK = 1'b1; rx[i] = MISO;
                @(negedge clk);
                @(negedge clk);
                mem_addr = 3'd0; spi_select = 1'b1; read_n = 1'b0;
                @(negedge clk);
                coll_data = data_to_cpu;
                spi_select = 1'b0; read_n = 1'b1;
                #60ns;
            end else begin
                SCLK = 1'b1; rx[i] = MISO;
                #HALF;
            end
            SCLK = 1'b0;
        end
    endtask

    task automatic frame_begin();
        SS_n = 1'b0;
        #HALF;
    endtask

    task automatic frame_end();
        #HALF;
        SS_n = 1'b1;
        #200ns;
    endtask

    initial begin
        #200us;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1; SCLK = 1'b0; SS_n = 1'b1; MOSI = 1'b0;
        spi_select = 1'b0; read_n = 1'b1; write_n = 1'b1;
        mem_addr = 3'd2; data_from_cpu = '0; coll_data = '0;
        repeat (3) @(negedge clk);
        check("rst_data", data_to_cpu, 16'h0000);
        check("rst_irq", {15'b0, irq}, 16'h0000);
        check("rst_miso", {15'b0, MISO}, 16'h0000);
        check("rst_oe", {15'b0, MISO_oe}, 16'h0000);
        reset = 1'b0;
        @(negedge clk);
        check("rst_status", data_to_cpu, 16'h0020);

        // Basic transfer; trailing reload with TRDY=1 underruns (TUR).
        cpu_wr(3'd1, 16'h00A5);
        peek(3'd2, rv);            check("tx_wr_status", rv, 16'h0000);
        frame_begin();
        check("oe_selected", {15'b0, MISO_oe}, 16'h0001);
        spi_byte(8'h3C, r1, 8, 0);
        frame_end();
        check("basic_miso", {8'h0, r1}, 16'h00A5);
        check("miso_idle", {15'b0, MISO}, 16'h0000);
        check("oe_idle", {15'b0, MISO_oe}, 16'h0000);
        peek(3'd2, rv);            check("basic_status", rv, 16'h00E8);
        cpu_rd(3'd0, rv);          check("basic_rx", rv, 16'h003C);
        peek(3'd2, rv);            check("rrdy_cleared", rv, 16'h00A8);
        cpu_wr(3'd2, 16'h0000);
        peek(3'd2, rv);            check("stat_clear", rv, 16'h0020);

        // Two bytes, one tx write, no read between: underrun + overrun.
        cpu_wr(3'd1, 16'h005A);
        frame_begin();
        spi_byte(8'h11, r1, 8, 0);
        spi_byte(8'h22, r2, 8, 0);
        frame_end();
        check("b2b_miso1", {8'h0, r1}, 16'h005A);
        check("b2b_miso2", {8'h0, r2}, 16'h0000);
        peek(3'd2, rv);            check("b2b_status", rv, 16'h00EC);
        cpu_wr(3'd2, 16'h0000);
        peek(3'd2, rv);            check("b2b_cleared", rv, 16'h0060);
        cpu_rd(3'd0, rv);          check("b2b_rx", rv, 16'h0022);
        peek(3'd2, rv);            check("b2b_final", rv, 16'h0020);

        // Abort after 5 bits, then a full frame.
        cpu_wr(3'd1, 16'h0081);
        frame_begin();
        spi_byte(8'hFF, r1, 5, 0);
        frame_end();
        peek(3'd2, rv);            check("abort_status", rv, 16'h0020);
        check("abort_miso", {15'b0, MISO}, 16'h0000);
        cpu_wr(3'd1, 16'h0042);
        frame_begin();
        spi_byte(8'h96, r1, 8, 0);
        frame_end();
        check("abort_next_miso", {8'h0, r1}, 16'h0042);
        cpu_rd(3'd0, rv);          check("abort_next_rx", rv, 16'h0096);
        cpu_wr(3'd2, 16'h0000);

        // Collision: RRDY already 1, read on the completing clk.
        frame_begin();
        spi_byte(8'h5C, r1, 8, 0);
        frame_end();
        cpu_wr(3'd2, 16'h0000);
        cpu_wr(3'd1, 16'h0033);
        frame_begin();
        spi_byte(8'hE7, r1, 8, 1);
        frame_end();
        check("coll_old_byte", coll_data, 16'h005C);
        check("coll_miso", {8'h0, r1}, 16'h0033);
        peek(3'd2, rv);            check("coll_status", rv, 16'h00E8);
        cpu_rd(3'd0, rv);          check("coll_rx", rv, 16'h00E7);
        cpu_wr(3'd2, 16'h0000);

        // Interrupt on TUR, enabled by iE only.
        cpu_wr(3'd3, 16'h0080);
        peek(3'd3, rv);            check("ctrl_rd", rv, 16'h0080);
        peek(3'd2, rv);            check("irq_pre_status", rv, 16'h0020);
        check("irq_idle", {15'b0, irq}, 16'h0000);
        @(negedge clk);
        SS_n = 1'b0;
        found = 1'b0;
        prev_irq = irq;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (data_to_cpu[3]) begin
                found = 1'b1;
                break;
            end
            prev_irq = irq;
        end
        check("tur_seen", {15'b0, found}, 16'h0001);
        check("irq_before_tur", {15'b0, prev_irq}, 16'h0000);
        check("irq_after_tur", {15'b0, irq}, 16'h0001);
        cpu_wr(3'd2, 16'h0000);
        check("irq_clear_edge", {15'b0, irq}, 16'h0001);
        @(negedge clk);
        check("irq_cleared", {15'b0, irq}, 16'h0000);
        SS_n = 1'b1;
        #200ns;

        // Reset mid-byte (control still 0x0080 going in).
        cpu_wr(3'd1, 16'h0077);
        mem_addr = 3'd2;
        frame_begin();
        spi_byte(8'hA0, r1, 3, 0);
        @(negedge clk); reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("mid_rst_data", data_to_cpu, 16'h0000);
        check("mid_rst_irq", {15'b0, irq}, 16'h0000);
        check("mid_rst_miso", {15'b0, MISO}, 16'h0000);
        check("mid_rst_oe", {15'b0, MISO_oe}, 16'h0000);
        reset = 1'b0;
        @(negedge clk);
        check("mid_rst_status", data_to_cpu, 16'h0020);
        SS_n = 1'b1;
        #200ns;
        peek(3'd2, rv);            check("mid_rst_rrdy", rv & 16'h0040, 16'h0000);
        peek(3'd3, rv);            check("mid_rst_ctrl", rv, 16'h0000);
        cpu_wr(3'd2, 16'h0000);
        cpu_wr(3'd1, 16'h003C);
        frame_begin();
        spi_byte(8'hC3, r1, 8, 0);
        frame_end();
        check("post_rst_miso", {8'h0, r1}, 16'h003C);
        cpu_rd(3'd0, rv);          check("post_rst_rx", rv, 16'h00C3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/touch_panel_spi_slave.md
TOUCH_PANEL_SPI_SLAVE -- requirements
Module: touch_panel_spi_slave

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-high reset: clk, reset.
REQ-002 Ports SHALL be, in order:
- clk  in  1  system clock, 80 MHz
- reset  in  1  synchronous active-high reset
- SCLK  in  1  SPI clock from the external master, asynchronous
- SS_n  in  1  slave select, active low, asynchronous
- MOSI  in  1  serial data in, asynchronous
- MISO  out  1  serial data out
- MISO_oe  out  1  MISO output enable, high while selected
- spi_select  in  1  CPU chip select
- mem_addr  in  3  register address
- read_n  in  1  CPU read strobe, active low
- write_n  in  1  CPU write strobe, active low
- data_from_cpu  in  16  write data
- data_to_cpu  out  16  read data, registered
- irq  out  1  interrupt, registered
REQ-003 The SPI format SHALL be fixed: CPOL=0, CPHA=0, 8 data bits, MSB first.

Function
REQ-004 SCLK, SS_n and MOSI SHALL each pass through a 2-flop synchronizer. Edges SHALL be detected from the synchronized value and one further delay flop; SCLK SHALL be no faster than clk/8.
REQ-005 The register map SHALL be: 0 rx data (r), 1 tx data (w), 2 status (r; any write clears ROE and TUR), 3 control (r/w).
REQ-006 Status SHALL be {8'b0, E, RRDY, TRDY, SEL, TUR, ROE, 2'b0} (bit 7 = E). SEL is synchronized ~SS_n. E = ROE | TUR.
REQ-007 Control SHALL be {8'b0, iE, iRRDY, iTRDY, 5'b0} (bit 7 = iE).
REQ-008 irq SHALL be registered from (E & iE) | (RRDY & iRRDY) | (TRDY & iTRDY).
REQ-009 data_to_cpu SHALL register the mem_addr-selected register every clk. Its value is valid one cycle after the address. Unmapped addresses read 0.
REQ-010 A CPU access SHALL occur on any clk where spi_select=1 and the corresponding strobe is low.
REQ-011 A tx write SHALL load tx_hold[7:0] and set TRDY=0.
REQ-012 A tx write while TRDY=0 SHALL be ignored.
REQ-013 An rx read (addr 0) SHALL clear RRDY.
REQ-014 The FSM SHALL have three states: IDLE, LOAD, SHIFT.
- IDLE: synchronized SS_n falling edge -> LOAD.
- LOAD: lasts one cycle; shift_reg <= tx_hold if TRDY=0, else 8'h00 with TUR set; TRDY set to 1; bit_cnt <= 0; -> SHIFT.
- SHIFT:
  - SCLK rising edge: rx_shift <= {rx_shift[6:0], MOSI_sync}; bit_cnt increments.
  - SCLK falling edge with bit_cnt 1..7: shift_reg <= {shift_reg[6:0], 0}.
  - SCLK falling edge with bit_cnt==8: reload shift_reg as in LOAD; bit_cnt <= 0.
REQ-015 On the 8th rising edge, rx_hold SHALL take the completed byte and RRDY SHALL be set; if RRDY was already 1, ROE SHALL also be set.
REQ-016 MISO SHALL be shift_reg[7]. MISO_oe SHALL be ~SS_n_sync. MISO SHALL be 0 in IDLE.
REQ-017 A synchronized SS_n rising edge in any state SHALL force IDLE, discard the partial byte and leave RRDY unchanged.
REQ-018 Byte completion and an rx read in the same cycle SHALL leave RRDY=1 and ROE unchanged.
REQ-019 A tx write in the same cycle as a LOAD/reload with TRDY=1 SHALL send 8'h00, set TUR, and hold the new byte (TRDY=0) for the next byte.
REQ-020 A status write and an ROE/TUR set event in the same cycle SHALL leave the set winning.

Reset
REQ-021 With reset=1 at a clk edge, the following SHALL be cleared: FSM=IDLE, shift_reg, rx_shift, rx_hold, tx_hold, bit_cnt=0, RRDY=0, ROE=0, TUR=0, control=0, data_to_cpu=0, irq=0, MISO=0, MISO_oe=0.
REQ-022 After the same reset: TRDY=1 and synchronizer flops=1 for SS_n, 0 for SCLK and MOSI.
REQ-023 Reset asserted mid-byte SHALL abort the transfer. The slave SHALL ignore the master until SS_n is next seen falling.

Verification
REQ-024 Basic transfer: write 0xA5 to addr 1; master sends 0x3C at clk/16 -> MISO shifts 1010_0101, rx read returns 0x003C, RRDY 1->0, TRDY=1.
REQ-025 Two back-to-back bytes without a second tx write and no rx read between them:
- MISO sends 0x00 on byte 2.
- Status reads with TUR=1, ROE=1, E=1.
- A status write clears all three.
REQ-026 Abort: SS_n deasserted after 5 bits -> FSM=IDLE, RRDY stays 0, next full frame receives correctly.
REQ-027 Collision: rx read on the same clk as the 8th rising edge -> RRDY=1 and ROE=0 afterwards.
REQ-028 Interrupt: control=0x0080, force TUR -> irq=1 one cycle after TUR sets. Writing status -> irq=0 one cycle after the clear.
REQ-029 Reset mid-byte: pulse reset after 3 bits -> all REQ-021/REQ-022 values hold; the next frame is received correctly.
